// File: rtl/pulse_sched_pkg.sv
// Shared state encoding and width constants for the comparator test pulse scheduler.
package pulse_sched_pkg;
  localparam int NPULSE_WIDTH = 12;
  localparam int ERRCNT_WIDTH = 16;
  localparam int RESP_WIDTH   = 8;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE, ARM, PULSE, DELAY, SAMPLE, RESTORE, FINISH
  } state_t;
endpackage

// File: rtl/pulse_scheduler_if.sv
// Register-file and pulser/comparator signals of the pulse scheduler.
interface pulse_scheduler_if #(
  parameter int NPULSE_W = pulse_sched_pkg::NPULSE_WIDTH,
  parameter int ERRCNT_W = pulse_sched_pkg::ERRCNT_WIDTH,
  parameter int RESP_W   = pulse_sched_pkg::RESP_WIDTH
);
  logic                fire_pulse;
  logic [NPULSE_W-1:0] num_pulses;
  logic [3:0]          pulse_width;
  logic [3:0]          bx_delay;
  logic [15:0]         restore_cnt;
  logic                compout_expect;
  logic                compout;
  logic                pulser_ready;
  logic                compout_errcnt_rst;
  logic                pulse_out;
  logic                busy;
  logic                done;
  logic                compout_last;
  logic [ERRCNT_W-1:0] compout_errcnt;
  logic [RESP_W-1:0]   response_time;
  logic                timeout;

  modport master (
    output fire_pulse, num_pulses, pulse_width, bx_delay, restore_cnt,
           compout_expect, compout, pulser_ready, compout_errcnt_rst,
    input  pulse_out, busy, done, compout_last, compout_errcnt, response_time, timeout
  );
  modport slave (
    input  fire_pulse, num_pulses, pulse_width, bx_delay, restore_cnt,
           compout_expect, compout, pulser_ready, compout_errcnt_rst,
    output pulse_out, busy, done, compout_last, compout_errcnt, response_time, timeout
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that clears on demand and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clock) begin
    if (reset || clr)        q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
  end
endmodule

// File: rtl/pulse_scheduler.sv
// Fires num_pulses test pulses, samples compout after each, and tracks mismatches and response time.
// Define PULSE_SCHED_TIMEOUT_EN to add a pulser_ready watchdog in ARM with a sticky timeout flag.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NPULSE_W = NPULSE_WIDTH,
  parameter int ERRCNT_W = ERRCNT_WIDTH,
  parameter int RESP_W   = RESP_WIDTH
) (
  input logic              clock,
  input logic              reset,
  pulse_scheduler_if.slave bus
);
  state_t              state;
  logic                fire_d, fire_edge;
  logic [NPULSE_W-1:0] pcnt;
  logic [15:0]         tmr;
  logic [16:0]         tmr_nx;
  logic [3:0]          pw_eff;
  logic                pulse_last, bx_last, restore_last;
  logic                resp_seen, arm_go, resp_inc, err_inc;
  logic                pulse_out, busy, done, compout_last;
  logic [RESP_W-1:0]   resp_cnt, response_time;
  logic [ERRCNT_W-1:0] errcnt;

  assign fire_edge    = bus.fire_pulse & ~fire_d;
  assign tmr_nx       = {1'b0, tmr} + 17'd1;
  assign pw_eff       = (bus.pulse_width == 4'd0) ? 4'd1 : bus.pulse_width;
  assign pulse_last   = tmr_nx >= {13'd0, pw_eff};
  assign bx_last      = tmr_nx >= {13'd0, bus.bx_delay};
  assign restore_last = tmr_nx >= {1'b0, bus.restore_cnt};

  assign arm_go   = (state == ARM) && bus.pulser_ready;
  assign resp_inc = (state == PULSE || state == DELAY) && !resp_seen && !bus.compout;
  assign err_inc  = (state == SAMPLE) && (bus.compout != bus.compout_expect);

  sat_counter #(.W(ERRCNT_W)) u_errcnt (
    .clock(clock), .reset(reset), .clr(bus.compout_errcnt_rst), .inc(err_inc), .q(errcnt)
  );
  // Response counter restarts on every pulse; only the last pulse's value survives to SAMPLE.
  sat_counter #(.W(RESP_W)) u_resp (
    .clock(clock), .reset(reset), .clr(arm_go), .inc(resp_inc), .q(resp_cnt)
  );

`ifdef PULSE_SCHED_TIMEOUT_EN
  logic [15:0] wd;
  logic        timeout;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      fire_d        <= 1'b0;
      pcnt          <= '0;
      tmr           <= '0;
      resp_seen     <= 1'b0;
      pulse_out     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      compout_last  <= 1'b0;
      response_time <= '0;
`ifdef PULSE_SCHED_TIMEOUT_EN
      wd            <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      fire_d <= bus.fire_pulse;
      done   <= 1'b0;
`ifdef PULSE_SCHED_TIMEOUT_EN
      if (state != ARM) wd <= '0;
`endif
      unique case (state)
        IDLE: if (fire_edge) begin
`ifdef PULSE_SCHED_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          if (bus.num_pulses == '0) state <= FINISH;
          else begin
            pcnt  <= bus.num_pulses;
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (bus.pulser_ready) begin
            pulse_out <= 1'b1;
            tmr       <= '0;
            resp_seen <= 1'b0;
            state     <= PULSE;
          end
`ifdef PULSE_SCHED_TIMEOUT_EN
          else if (wd == TIMEOUT_LIMIT - 16'd1) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end else wd <= wd + 16'd1;
`endif
        end
        PULSE: begin
          if (bus.compout) resp_seen <= 1'b1;
          if (pulse_last) begin
            pulse_out <= 1'b0;
            tmr       <= '0;
            state     <= DELAY;
          end else tmr <= tmr_nx[15:0];
        end
        DELAY: begin
          if (bus.compout) resp_seen <= 1'b1;
          if (bx_last) begin
            tmr   <= '0;
            state <= SAMPLE;
          end else tmr <= tmr_nx[15:0];
        end
        SAMPLE: begin
          compout_last  <= bus.compout;
          response_time <= (resp_seen || bus.compout) ? resp_cnt : '1;
          pcnt          <= pcnt - NPULSE_W'(1);
          tmr           <= '0;
          if (pcnt == NPULSE_W'(1))      state <= FINISH;
          else if (bus.restore_cnt == 0) state <= ARM;
          else                           state <= RESTORE;
        end
        RESTORE: begin
          if (restore_last) begin
            tmr   <= '0;
            state <= ARM;
          end else tmr <= tmr_nx[15:0];
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_out      = pulse_out;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.compout_last   = compout_last;
  assign bus.compout_errcnt = errcnt;
  assign bus.response_time  = response_time;
`ifdef PULSE_SCHED_TIMEOUT_EN
  assign bus.timeout        = timeout;
`else
  assign bus.timeout        = 1'b0;
`endif
endmodule
